// File: rtl/mod_n_seq_ctrl.sv
// mod_n_seq_ctrl: run controller for a programmable mod-N counter.
// Captures modulus and repeat count on start, then sequences the count
// through run, pause, resume and stop. Emits tc on every wrap and a done
// pulse when the programmed number of periods completes.
//
// Ports:
//   clk        - clock, all state updates on posedge
//   rstn       - asynchronous active-low reset
//   start      - begin a run (sampled in IDLE only)
//   stop       - abort run, highest priority
//   pause      - level, holds the count while high
//   mod_n      - modulus N, count runs 0..N-1 (legal 2..2^WIDTH-1)
//   repeat_cnt - periods per run, 0 = continuous
//   cnt_out    - current count value
//   tc         - high while running with cnt_out == N-1 (combinational)
//   period     - periods completed in the current run
//   busy       - high in RUN or PAUSE (combinational)
//   done       - one-cycle pulse at normal run completion
//   cfg_err    - one-cycle pulse on start with illegal mod_n
module mod_n_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RPT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] mod_n,
  input  logic [RPT_W-1:0] repeat_cnt,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic [RPT_W-1:0] period,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [RPT_W-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  // Last count value of a period; n_q >= 2 whenever it matters, so no underflow.
  logic [WIDTH-1:0] n_last;
  // Wrap that finishes the final programmed period.
  logic             last_period;

  assign n_last      = n_q - WIDTH'(1);
  assign last_period = (r_q != '0) && (period_q == (r_q - RPT_W'(1)));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      n_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      n_q       <= n_d;
      r_q       <= r_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic; priority is stop > pause > count/wrap > start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    n_d       = n_q;
    r_d       = r_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (mod_n >= WIDTH'(2)) begin
            n_d      = mod_n;
            r_d      = repeat_cnt;
            cnt_d    = '0;
            period_d = '0;
            state_d  = S_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (stop) begin
          cnt_d    = '0;
          period_d = '0;
          state_d  = S_IDLE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (cnt_q != n_last) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          cnt_d = '0;
          if (last_period) begin
            period_d = '0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            period_d = period_q + RPT_W'(1);
          end
        end
      end

      S_PAUSE: begin
        if (stop) begin
          cnt_d    = '0;
          period_d = '0;
          state_d  = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      default: begin
        cnt_d    = '0;
        period_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign cnt_out = cnt_q;
  assign period  = period_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign tc      = (state_q == S_RUN) && (cnt_q == n_last);

endmodule

// File: tb/tb_mod_n_seq_ctrl.sv
// Directed testbench for mod_n_seq_ctrl (WIDTH=4, RPT_W=8).
module tb_mod_n_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] mod_n;
  logic [7:0] repeat_cnt;
  logic [3:0] cnt_out;
  logic       tc;
  logic [7:0] period;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int vectors     = 0;
  int miscompares = 0;

  mod_n_seq_ctrl #(.WIDTH(4), .RPT_W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .mod_n      (mod_n),
    .repeat_cnt (repeat_cnt),
    .cnt_out    (cnt_out),
    .tc         (tc),
    .period     (period),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},   32'(busy),    0);
    chk({tag, ".cnt"},    32'(cnt_out), 0);
    chk({tag, ".period"}, 32'(period),  0);
    chk({tag, ".tc"},     32'(tc),      0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int tc_seen;
    int busy_cnt;
    int k;

    rstn = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mod_n = 4'd10; repeat_cnt = 8'd2;

    // Reset held two cycles with start toggling.
    step(); start = 1'b1;
    step(); start = 1'b0;
    chk_idle("reset");
    chk("reset.done",    32'(done),    0);
    chk("reset.cfg_err", 32'(cfg_err), 0);
    rstn = 1'b1;
    step();

    // N=10, repeat=2: 20 busy cycles, tc twice, then done.
    mod_n = 4'd10; repeat_cnt = 8'd2; start = 1'b1;
    step(); start = 1'b0;
    tc_seen = 0;
    for (int i = 0; i < 20; i++) begin
      chk("run2.cnt",    32'(cnt_out), 32'(i % 10));
      chk("run2.period", 32'(period),  32'(i / 10));
      chk("run2.busy",   32'(busy),    1);
      chk("run2.tc",     32'(tc),      32'((i % 10) == 9));
      if (tc) tc_seen++;
      step();
    end
    chk("run2.tc_count", 32'(tc_seen), 2);
    chk("run2.done",     32'(done),    1);
    chk_idle("run2.end");
    step();
    chk("run2.done_clr", 32'(done), 0);

    // Continuous run, stop after 25 cycles.
    repeat_cnt = 8'd0; start = 1'b1;
    step(); start = 1'b0;
    repeat (24) step();
    chk("cont.cnt",    32'(cnt_out), 4);
    chk("cont.period", 32'(period),  2);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk_idle("cont.stop");
    chk("cont.done", 32'(done), 0);
    step();
    chk("cont.done2", 32'(done), 0);

    // Pause for 3 cycles at cnt=4 with repeat=1.
    repeat_cnt = 8'd1; start = 1'b1;
    step(); start = 1'b0;
    busy_cnt = 0;
    repeat (4) begin
      busy_cnt += 32'(busy);
      step();
    end
    chk("pause.cnt_at_raise", 32'(cnt_out), 4);
    pause = 1'b1;
    repeat (3) begin
      busy_cnt += 32'(busy);
      step();
      chk("pause.hold_cnt", 32'(cnt_out), 4);
      chk("pause.hold_tc",  32'(tc),      0);
      chk("pause.busy",     32'(busy),    1);
    end
    busy_cnt += 32'(busy);
    pause = 1'b0;
    step();
    chk("pause.resume_cnt", 32'(cnt_out), 4);
    busy_cnt += 32'(busy);
    step();
    chk("pause.next_cnt", 32'(cnt_out), 5);
    k = 0;
    while (!done && k < 40) begin
      busy_cnt += 32'(busy);
      step();
      k++;
    end
    chk("pause.done_seen",  32'(done),     1);
    chk("pause.busy_total", 32'(busy_cnt), 14);
    chk_idle("pause.end");
    step();

    // Illegal moduli pulse cfg_err and stay idle.
    mod_n = 4'd1; start = 1'b1;
    step(); start = 1'b0;
    chk("cfg1.err",  32'(cfg_err), 1);
    chk("cfg1.busy", 32'(busy),    0);
    chk("cfg1.done", 32'(done),    0);
    step();
    chk("cfg1.err_clr", 32'(cfg_err), 0);
    mod_n = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("cfg0.err",  32'(cfg_err), 1);
    chk("cfg0.busy", 32'(busy),    0);
    step();
    chk("cfg0.err_clr", 32'(cfg_err), 0);

    // mod_n change mid-run does not alter the sequence.
    mod_n = 4'd10; repeat_cnt = 8'd1; start = 1'b1;
    step(); start = 1'b0; mod_n = 4'd3;
    repeat (3) step();
    chk("shadow.cnt3", 32'(cnt_out), 3);
    chk("shadow.tc3",  32'(tc),      0);
    repeat (6) step();
    chk("shadow.cnt9", 32'(cnt_out), 9);
    chk("shadow.tc9",  32'(tc),      1);
    step();
    chk("shadow.done", 32'(done), 1);
    chk_idle("shadow.end");
    mod_n = 4'd10;
    step();

    // stop and pause together in RUN.
    repeat_cnt = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    repeat (2) step();
    chk("sp.cnt", 32'(cnt_out), 2);
    stop = 1'b1; pause = 1'b1;
    step(); stop = 1'b0; pause = 1'b0;
    chk_idle("sp.idle");
    step();
    chk("sp.still_idle", 32'(busy), 0);

    // stop at the final wrap gives no done.
    repeat_cnt = 8'd2; start = 1'b1;
    step(); start = 1'b0;
    repeat (19) step();
    chk("sw.cnt",    32'(cnt_out), 9);
    chk("sw.period", 32'(period),  1);
    chk("sw.tc",     32'(tc),      1);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk_idle("sw.idle");
    chk("sw.done", 32'(done), 0);
    step();
    chk("sw.done2", 32'(done), 0);

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    chk("ss.busy",    32'(busy),    0);
    chk("ss.cfg_err", 32'(cfg_err), 0);
    step();
    chk("ss.busy2", 32'(busy), 0);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    repeat_cnt = 8'd0; start = 1'b1;
    step(); start = 1'b0;
    repeat (13) step();
    chk("ar.cnt_pre",    32'(cnt_out), 3);
    chk("ar.period_pre", 32'(period),  1);
    #2 rstn = 1'b0;
    #1;
    chk_idle("ar.async");
    chk("ar.done", 32'(done), 0);
    step();
    rstn = 1'b1;
    step();
    chk("ar.after", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
